// File: rtl/serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and the serial line idle level.
package serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } ser_state_t;

    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_serializer_piso.sv
// Parallel-in/serial-out word serializer feeding sequence_detector, one bit per clock.
// Latency: first bit on ser_out one cycle after the accept edge; all outputs registered.
// Backpressure: data_ready low while shifting (except last bit when gapless) and during the gap.
module bit_serializer_piso
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    // The IDLE cycle that takes the next word is itself one of the idle gap cycles,
    // so the GAP state only has to cover GAP_CYCLES-1 of them.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    ser_state_t       state, state_nxt;
    logic [CW-1:0]    bit_cnt, cnt_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic [WIDTH-1:0] load_word;
    logic             accept;
    logic             ser_out_nxt, ser_valid_nxt, word_done_nxt, busy_nxt, ready_nxt;

    // The shifter always emits from the top bit; LSB-first words are reversed on load.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign load_word = data_in;
        end else begin : g_lsb_first
            for (genvar i = 0; i < WIDTH; i++) begin : g_rev
                assign load_word[i] = data_in[WIDTH-1-i];
            end
        end
    endgenerate

    always_comb begin
        accept    = data_valid && data_ready;
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        gap_nxt   = gap_cnt;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = '0;
                    shift_nxt = load_word;
                end
            end
            S_SHIFT: begin
                if (bit_cnt != LAST_BIT) begin
                    cnt_nxt   = bit_cnt + 1'b1;
                    shift_nxt = {shift_reg[WIDTH-2:0], IDLE_LEVEL};
                end else if (accept) begin
                    cnt_nxt   = '0;
                    shift_nxt = load_word;
                end else if (GAP_CYCLES > 1) begin
                    state_nxt = S_GAP;
                    gap_nxt   = GAP_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        ser_valid_nxt = (state_nxt == S_SHIFT);
        ser_out_nxt   = ser_valid_nxt ? shift_nxt[WIDTH-1] : IDLE_LEVEL;
        word_done_nxt = ser_valid_nxt && (cnt_nxt == LAST_BIT);
        busy_nxt      = (state_nxt != S_IDLE);
        ready_nxt     = (state_nxt == S_IDLE) || ((GAP_CYCLES == 0) && word_done_nxt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            gap_cnt    <= '0;
            data_ready <= 1'b0;
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            shift_reg  <= shift_nxt;
            gap_cnt    <= gap_nxt;
            data_ready <= ready_nxt;
            ser_out    <= ser_out_nxt;
            ser_valid  <= ser_valid_nxt;
            word_done  <= word_done_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bit_serializer_piso.sv
// Bench for bit_serializer_piso: three parameterisations checked every cycle against a word-level model.
module tb_bit_serializer_piso;

    localparam int NI = 3;
    localparam int GP [NI] = '{0, 2, 0};
    localparam bit MP [NI] = '{1'b1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din [NI];
    logic       dv [NI];
    logic       dr [NI];
    logic       so [NI];
    logic       sv [NI];
    logic       wd [NI];
    logic       bz [NI];

    always #5 clk = ~clk;

    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_b2b (
        .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .word_done(wd[0]), .busy(bz[0]));
    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .word_done(wd[1]), .busy(bz[1]));
    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(din[2]), .data_valid(dv[2]), .data_ready(dr[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .word_done(wd[2]), .busy(bz[2]));

    // Word-level model: the captured word, bits still to show, idle gap cycles left.
    logic [7:0] mword [NI];
    int         mrem [NI];
    int         mgap [NI];
    bit         mrst [NI];
    bit         macc [NI];
    bit         started = 1'b0;

    // Per-scenario log of what actually left each instance.
    logic [31:0] strm [NI];
    int nbits [NI];
    int first_c [NI];
    int last_c [NI];
    int ndone [NI];
    int nrdy_busy [NI];
    int cyc = 0;

    int checks = 0;
    int errors = 0;

    function automatic bit e_valid(int k);
        return mrem[k] > 0;
    endfunction

    function automatic bit e_out(int k);
        int pos;
        if (mrem[k] == 0) return 1'b0;
        pos = 8 - mrem[k];
        return MP[k] ? mword[k][7-pos] : mword[k][pos];
    endfunction

    function automatic bit e_ready(int k);
        if (mrst[k]) return 1'b0;
        return (mrem[k] == 0 && mgap[k] == 0) || (GP[k] == 0 && mrem[k] == 1);
    endfunction

    task automatic chk_bit(string name, int k, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d: got %b expected %b", name, k, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_and_log();
        cyc++;
        if (!started) return;
        for (int k = 0; k < NI; k++) begin
            chk_bit("ser_valid", k, sv[k], e_valid(k));
            chk_bit("ser_out", k, so[k], e_out(k));
            chk_bit("word_done", k, wd[k], mrem[k] == 1);
            chk_bit("busy", k, bz[k], (mrem[k] > 0) || (mgap[k] > 0));
            chk_bit("data_ready", k, dr[k], e_ready(k));
            if (sv[k] === 1'b1) begin
                if (nbits[k] == 0) first_c[k] = cyc;
                last_c[k] = cyc;
                strm[k] = {strm[k][30:0], so[k]};
                nbits[k]++;
            end
            if (wd[k] === 1'b1) ndone[k]++;
            if (dr[k] === 1'b1 && bz[k] === 1'b1) nrdy_busy[k]++;
        end
    endtask

    task automatic model_edge();
        bit acc;
        started = 1'b1;
        for (int k = 0; k < NI; k++) begin
            acc = reset && dv[k] && e_ready(k);
            macc[k] = acc;
            if (!reset) begin
                mrem[k] = 0;
                mgap[k] = 0;
                mrst[k] = 1'b1;
            end else begin
                mrst[k] = 1'b0;
                if (mrem[k] > 0) begin
                    mrem[k]--;
                    if (mrem[k] == 0 && GP[k] > 1) mgap[k] = GP[k] - 1;
                end else if (mgap[k] > 0) begin
                    mgap[k]--;
                end
                if (acc) begin
                    mword[k] = din[k];
                    mrem[k] = 8;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_and_log();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        for (int k = 0; k < NI; k++) begin
            strm[k] = '0;
            nbits[k] = 0;
            first_c[k] = 0;
            last_c[k] = 0;
            ndone[k] = 0;
            nrdy_busy[k] = 0;
        end
    endtask

    task automatic send(int k, logic [7:0] w, bit hold);
        bit got;
        got = 1'b0;
        din[k] = w;
        dv[k] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = macc[k];
        end
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout[%0d]: word %0h not accepted within 40 cycles", k, w);
        end
        checks++;
        if (!hold) dv[k] = 1'b0;
        din[k] = 8'($urandom);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            din[k] = '0;
            dv[k] = 1'b0;
            mword[k] = '0;
            mrem[k] = 0;
            mgap[k] = 0;
            mrst[k] = 1'b1;
            macc[k] = 1'b0;
        end
        clear_log();

        // Reset state and release.
        reset = 1'b0;
        idle(2);
        chk_int("reset_ready", int'(dr[0]), 0);
        chk_int("reset_valid", int'(sv[1]), 0);
        chk_int("reset_busy", int'(bz[2]), 0);
        reset = 1'b1;
        tick();
        chk_int("release_ready", int'(dr[0]), 1);

        // Single word, MSB first.
        clear_log();
        send(0, 8'hB0, 1'b0);
        idle(12);
        chk_int("single_bits", strm[0][7:0], 8'hB0);
        chk_int("single_nbits", nbits[0], 8);
        chk_int("single_span", last_c[0] - first_c[0], 7);
        chk_int("single_done", ndone[0], 1);

        // Back-to-back words with no gap.
        clear_log();
        send(0, 8'hB0, 1'b1);
        send(0, 8'h0B, 1'b0);
        idle(20);
        chk_int("b2b_bits", strm[0][15:0], 16'hB00B);
        chk_int("b2b_span", last_c[0] - first_c[0], 15);
        chk_int("b2b_done", ndone[0], 2);
        chk_int("b2b_ready_busy", nrdy_busy[0], 2);

        // Two-cycle gap between words with valid held.
        clear_log();
        send(1, 8'h5A, 1'b1);
        send(1, 8'hC3, 1'b0);
        idle(20);
        chk_int("gap_bits", strm[1][15:0], 16'h5AC3);
        chk_int("gap_span", last_c[1] - first_c[1], 17);
        chk_int("gap_done", ndone[1], 2);

        // LSB first.
        clear_log();
        send(2, 8'h0D, 1'b0);
        idle(12);
        chk_int("lsb_bits", strm[2][7:0], 8'hB0);

        // Reset at bit 4 abandons the word.
        clear_log();
        send(0, 8'hFF, 1'b0);
        idle(3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_int("abort_ready", int'(dr[0]), 1);
        chk_int("abort_valid", int'(sv[0]), 0);
        chk_int("abort_out", int'(so[0]), 0);
        chk_int("abort_done", ndone[0], 0);
        chk_int("abort_nbits", nbits[0], 4);
        clear_log();
        send(0, 8'hA5, 1'b0);
        idle(12);
        chk_int("after_abort_bits", strm[0][7:0], 8'hA5);
        chk_int("after_abort_done", ndone[0], 1);

        // Random traffic: toggling valid, data changing every cycle, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NI; k++) begin
                dv[k] = 1'($urandom_range(0, 1));
                din[k] = 8'($urandom);
            end
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;
        for (int k = 0; k < NI; k++) dv[k] = 1'b0;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
